// File: rtl/riscv_seq_ctrl.sv
// rtl/riscv_seq_ctrl.sv - RV32I multi-cycle sequencer: fetch, decode, branch resolve, memory and write-back control
module riscv_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    input  logic        Z,
    input  logic        N,
    input  logic        V,
    input  logic [31:0] pcimm,
    input  logic [31:0] aluout,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        imem_req,
    output logic        r,
    output logic        i,
    output logic        s,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        ui,
    output logic        u_control,
    output logic [3:0]  alu_op,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        wb_mem,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef struct packed {
        logic       r;
        logic       i;
        logic       s;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       ui;
        logic       u_control;
        logic [3:0] alu_op;
        logic       load;
        logic       store;
        logic       writes;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] next_pc_q, next_pc_d;
    ctrl_t       ctrl_q, ctrl_d;
    ctrl_t       dec;
    logic        taken;

    // Decode straight off the fetch bus so the controls are already valid in DECODE.
    always_comb begin
        dec = '0;
        case (instr_in[6:0])
            OPC_OP: begin
                dec.r      = 1'b1;
                dec.alu_op = {instr_in[30], instr_in[14:12]};
                dec.writes = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.i      = 1'b1;
                dec.alu_op = {(instr_in[14:12] == 3'b101) ? instr_in[30] : 1'b0, instr_in[14:12]};
                dec.writes = 1'b1;
            end
            OPC_LOAD: begin
                dec.i      = 1'b1;
                dec.load   = 1'b1;
                dec.writes = 1'b1;
            end
            OPC_STORE: begin
                dec.s     = 1'b1;
                dec.store = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = (instr_in[14:13] == 2'b11) ? 4'b0011 : 4'b1000;
            end
            OPC_JAL: begin
                dec.jal    = 1'b1;
                dec.writes = 1'b1;
            end
            OPC_JALR: begin
                dec.i      = 1'b1;
                dec.jalr   = 1'b1;
                dec.writes = 1'b1;
            end
            OPC_LUI: begin
                dec.ui        = 1'b1;
                dec.u_control = 1'b1;
                dec.writes    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.ui     = 1'b1;
                dec.writes = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Unsigned branches lean on the ALU's compare result surfacing through Z.
    always_comb begin
        case (ir_q[14:12])
            3'b000:  taken = Z;
            3'b001:  taken = ~Z;
            3'b100:  taken = N ^ V;
            3'b101:  taken = ~(N ^ V);
            3'b110:  taken = ~Z;
            3'b111:  taken = Z;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        next_pc_d = next_pc_q;
        ctrl_d    = ctrl_q;
        case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    ir_d    = instr_in;
                    ctrl_d  = dec;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (ctrl_q.illegal) begin
                    ctrl_d  = '0;
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ctrl_q.jalr) begin
                    next_pc_d = aluout & ~32'd1;
                end else if (ctrl_q.jal || (ctrl_q.branch && taken)) begin
                    next_pc_d = pcimm;
                end else begin
                    next_pc_d = pc_q + 32'd4;
                end
                state_d = (ctrl_q.load || ctrl_q.store) ? MEM : WB;
            end
            MEM: begin
                if (dmem_ready) begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_d    = next_pc_q;
                ctrl_d  = '0;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            next_pc_q <= RESET_PC;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            next_pc_q <= next_pc_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Gating with reset drops a pending request the moment reset is raised.
    assign imem_req  = (state_q == FETCH) & ~reset;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign r         = ctrl_q.r;
    assign i         = ctrl_q.i;
    assign s         = ctrl_q.s;
    assign branch    = ctrl_q.branch;
    assign jal       = ctrl_q.jal;
    assign jalr      = ctrl_q.jalr;
    assign ui        = ctrl_q.ui;
    assign u_control = ctrl_q.u_control;
    assign alu_op    = ctrl_q.alu_op;
    assign dmem_re   = (state_q == MEM) & ctrl_q.load;
    assign dmem_we   = (state_q == MEM) & ctrl_q.store;
    assign rf_we     = (state_q == WB) & ctrl_q.writes & (ir_q[11:7] != 5'd0);
    assign wb_mem    = (state_q == WB) & ctrl_q.load;
    assign halted    = (state_q == HALT);
endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// tb/tb_riscv_seq_ctrl.sv - scoreboard bench for riscv_seq_ctrl
module tb_riscv_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] instr_in, pcimm, aluout;
    logic        imem_valid, dmem_ready, Z, N, V;
    logic [31:0] pc, ir;
    logic        imem_req, r, i, s, branch, jal, jalr, ui, u_control;
    logic [3:0]  alu_op;
    logic        dmem_re, dmem_we, rf_we, wb_mem, halted;
    logic [11:0] ctl_now;

    riscv_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .imem_valid(imem_valid),
        .dmem_ready(dmem_ready), .Z(Z), .N(N), .V(V), .pcimm(pcimm), .aluout(aluout),
        .pc(pc), .ir(ir), .imem_req(imem_req), .r(r), .i(i), .s(s), .branch(branch),
        .jal(jal), .jalr(jalr), .ui(ui), .u_control(u_control), .alu_op(alu_op),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we), .wb_mem(wb_mem), .halted(halted)
    );

    assign ctl_now = {r, i, s, branch, jal, jalr, ui, u_control, alu_op};

    typedef struct {
        logic [31:0] ir, pcimm, aluout;
        logic [2:0]  znv;
        int          fdelay, mdelay;
        logic [11:0] ctl;
        int          lat, rfwe, wbmem, dre, dwe;
        logic [31:0] pc;
        logic        halt;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [11:0] ctl;
        int          fetch, lat, rfwe, wbmem, dre, dwe;
        logic [31:0] pc;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ir_v, pcimm_v, aluout_v, input logic [2:0] znv,
                                input int fd, md, input logic [11:0] ctl, input int lat, rfwe,
                                wbm, dre, dwe, input logic [31:0] pc_v, input logic halt);
        vec_t v;
        v.ir = ir_v; v.pcimm = pcimm_v; v.aluout = aluout_v; v.znv = znv;
        v.fdelay = fd; v.mdelay = md; v.ctl = ctl; v.lat = lat; v.rfwe = rfwe;
        v.wbmem = wbm; v.dre = dre; v.dwe = dwe; v.pc = pc_v; v.halt = halt;
        return v;
    endfunction

    // Monitor: one observation per instruction, from the fall of imem_req to its next rise (or halt)
    logic        prev_req = 1'b0;
    logic        active = 1'b0;
    logic        unstable;
    logic [31:0] snap_ir;
    logic [11:0] snap_ctl;
    int          req_cnt = 0;
    int          fetch_cnt, lat_cnt, rfwe_cnt, wbmem_cnt, dre_cnt, dwe_cnt;

    task automatic retire();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("ir", snap_ir, e.ir);
        chk("ctl", {20'd0, snap_ctl}, {20'd0, e.ctl});
        chk("ctl_stable", {31'd0, unstable}, 32'd0);
        chk("fetch_cycles", fetch_cnt, e.fetch);
        chk("latency", lat_cnt, e.lat);
        chk("rf_we_cycles", rfwe_cnt, e.rfwe);
        chk("wb_mem_cycles", wbmem_cnt, e.wbmem);
        chk("dmem_re_cycles", dre_cnt, e.dre);
        chk("dmem_we_cycles", dwe_cnt, e.dwe);
        chk("pc", pc, e.pc);
        chk("halted", {31'd0, halted}, {31'd0, e.halt});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            active   = 1'b0;
            prev_req = 1'b0;
            req_cnt  = 0;
        end else begin
            if (!imem_req && prev_req && !halted && !active) begin
                active    = 1'b1;
                snap_ir   = ir;
                snap_ctl  = ctl_now;
                unstable  = 1'b0;
                fetch_cnt = req_cnt;
                req_cnt   = 0;
                lat_cnt   = 0;
                rfwe_cnt  = 0;
                wbmem_cnt = 0;
                dre_cnt   = 0;
                dwe_cnt   = 0;
            end
            if (active && !imem_req) begin
                lat_cnt++;
                if (rf_we) rfwe_cnt++;
                if (wb_mem) wbmem_cnt++;
                if (dmem_re) dre_cnt++;
                if (dmem_we) dwe_cnt++;
                if (!halted && ctl_now != snap_ctl) unstable = 1'b1;
            end
            if (active && (imem_req || halted)) begin
                retire();
                active = 1'b0;
            end
            if (imem_req) req_cnt++;
            prev_req = imem_req;
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        int   mcnt;
        e.ir = v.ir; e.ctl = v.ctl; e.fetch = v.fdelay + 1; e.lat = v.lat; e.rfwe = v.rfwe;
        e.wbmem = v.wbmem; e.dre = v.dre; e.dwe = v.dwe; e.pc = v.pc; e.halt = v.halt;
        exp_q.push_back(e);
        instr_in = v.ir;
        pcimm    = v.pcimm;
        aluout   = v.aluout;
        {Z, N, V} = v.znv;
        n = 0;
        while (!imem_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            chk("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (v.fdelay) @(posedge clk);
        #1 imem_valid = 1'b1;
        @(posedge clk);
        #1 imem_valid = 1'b0;
        n = 0;
        mcnt = 0;
        while (!imem_req && !halted && n < 100) begin
            if (dmem_re || dmem_we) begin
                dmem_ready = (mcnt == v.mdelay);
                mcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        dmem_ready = 1'b0;
        if (n >= 100) chk("exec_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; instr_in = '0; imem_valid = 1'b0; dmem_ready = 1'b0;
        Z = 1'b0; N = 1'b0; V = 1'b0; pcimm = '0; aluout = '0;

        //             ir            pcimm         aluout        ZNV     fd md ctl     lat rf wm re we pc            halt
        vecs.push_back(mk(32'h00500093, 32'h0,        32'h0,        3'b000, 0, 0, 12'h400, 3, 1, 0, 0, 0, 32'h4,        1'b0));
        vecs.push_back(mk(32'h402081B3, 32'h0,        32'h0,        3'b000, 3, 0, 12'h808, 3, 1, 0, 0, 0, 32'h8,        1'b0));
        vecs.push_back(mk(32'h0000006F, 32'h10,       32'h0,        3'b000, 0, 0, 12'h080, 3, 0, 0, 0, 0, 32'h10,       1'b0));
        vecs.push_back(mk(32'h00208463, 32'h40,       32'h0,        3'b100, 0, 0, 12'h108, 3, 0, 0, 0, 0, 32'h40,       1'b0));
        vecs.push_back(mk(32'h0000006F, 32'h10,       32'h0,        3'b000, 0, 0, 12'h080, 3, 0, 0, 0, 0, 32'h10,       1'b0));
        vecs.push_back(mk(32'h00208463, 32'h40,       32'h0,        3'b000, 0, 0, 12'h108, 3, 0, 0, 0, 0, 32'h14,       1'b0));
        vecs.push_back(mk(32'h0020C463, 32'h80,       32'h0,        3'b011, 0, 0, 12'h108, 3, 0, 0, 0, 0, 32'h18,       1'b0));
        vecs.push_back(mk(32'h0020E463, 32'h20,       32'h0,        3'b000, 0, 0, 12'h103, 3, 0, 0, 0, 0, 32'h20,       1'b0));
        vecs.push_back(mk(32'h000100E7, 32'h500,      32'h103,      3'b100, 0, 0, 12'h440, 3, 1, 0, 0, 0, 32'h102,      1'b0));
        vecs.push_back(mk(32'h0000A283, 32'h0,        32'h1000,     3'b000, 0, 2, 12'h400, 6, 1, 1, 3, 0, 32'h106,      1'b0));
        vecs.push_back(mk(32'h0020A023, 32'h0,        32'h1004,     3'b000, 1, 0, 12'h200, 4, 0, 0, 0, 1, 32'h10A,      1'b0));
        vecs.push_back(mk(32'h4030D213, 32'h0,        32'h0,        3'b000, 0, 0, 12'h40D, 3, 1, 0, 0, 0, 32'h10E,      1'b0));
        vecs.push_back(mk(32'hC0008093, 32'h0,        32'h0,        3'b000, 0, 0, 12'h400, 3, 1, 0, 0, 0, 32'h112,      1'b0));
        vecs.push_back(mk(32'h12345337, 32'h0,        32'h0,        3'b000, 0, 0, 12'h030, 3, 1, 0, 0, 0, 32'h116,      1'b0));
        vecs.push_back(mk(32'h00000017, 32'h0,        32'h0,        3'b000, 0, 0, 12'h020, 3, 0, 0, 0, 0, 32'h11A,      1'b0));
        vecs.push_back(mk(32'h0000006F, 32'hFFFFFFFC, 32'h0,        3'b000, 0, 0, 12'h080, 3, 0, 0, 0, 0, 32'hFFFFFFFC, 1'b0));
        vecs.push_back(mk(32'h00000013, 32'h0,        32'h0,        3'b000, 0, 0, 12'h400, 3, 0, 0, 0, 0, 32'h0,        1'b0));
        vecs.push_back(mk(32'h0000007F, 32'h0,        32'h0,        3'b000, 0, 0, 12'h000, 2, 0, 0, 0, 0, 32'h0,        1'b1));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ctl", {20'd0, ctl_now}, 32'd0);
        chk("rst_rf_we_wb_mem", {30'd0, rf_we, wb_mem}, 32'd0);
        chk("rst_dmem", {30'd0, dmem_re, dmem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        #1 chk("first_fetch_req", {31'd0, imem_req}, 32'd1);

        foreach (vecs[k]) run_vec(vecs[k]);

        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (imem_req) n++;
        end
        chk("halt_no_fetch", n, 0);
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        reset = 1'b1;
        #1;
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        chk("halt_rst_imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        instr_in = 32'h0000A283;
        aluout   = 32'h2000;
        #1 imem_valid = 1'b1;
        @(posedge clk);
        #1 imem_valid = 1'b0;
        n = 0;
        while (!dmem_re && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_mem", {31'd0, dmem_re}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_dmem_re", {31'd0, dmem_re}, 32'd0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_ir", ir, 32'h0);
        chk("abort_imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("abort_fetch_req", {31'd0, imem_req}, 32'd1);
        run_vec(mk(32'h00500093, 32'h0, 32'h0, 3'b000, 0, 0, 12'h400, 3, 1, 0, 0, 0, 32'h4, 1'b0));

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_seq_ctrl.md
Name: riscv_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I DataPath block.
- Owns PC and the instruction register (IR); fetches via an instruction-memory handshake; decodes IR into the DataPath control strobes (r, i, s, branch, jal, jalr, ui, u_control, alu_op).
- Resolves branches from the DataPath Z/N/V flags; issues data-memory handshakes and register-file write enables.
- Sits between the instruction/data memory interfaces and DataPath + register file. Immediate generation is external, driven from ir.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_in  in  32  fetched instruction word.
- imem_valid  in  1  instr_in valid; sampled only in FETCH.
- dmem_ready  in  1  data access complete; sampled only in MEM.
- Z, N, V  in  1 each  DataPath ALU flags.
- pcimm  in  32  DataPath pc+imm (branch/jal target).
- aluout  in  32  DataPath ALU result (jalr target, memory address).
- pc  out  32  current PC to DataPath and instruction memory.
- ir  out  32  latched instruction to immediate generator and register file.
- imem_req  out  1  fetch request.
- r, i, s, branch, jal, jalr, ui, u_control  out  1 each  DataPath controls.
- alu_op  out  4  {switch, operation}.
- dmem_re, dmem_we  out  1 each  load/store request.
- rf_we  out  1  register-file write strobe.
- wb_mem  out  1  write-back source is load data (not DataPath regwrite).
- halted  out  1  illegal opcode seen.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async):
  - state=FETCH, pc=RESET_PC, ir=0.
  - All strobes, alu_op, rf_we, dmem_*, halted = 0.
  - imem_req is deasserted immediately and any in-flight handshake is abandoned.
  - After reset release, imem_req asserts in the first FETCH cycle.
- FETCH:
  - imem_req=1, held until a clock edge with imem_valid=1.
  - At that edge ir<=instr_in and state goes to DECODE.
  - imem_valid high in any other state is ignored.
- DECODE (1 cycle):
  - Controls are a registered decode of ir and stay stable from DECODE through WB.
  - OP → r=1, alu_op={ir[30],ir[14:12]}.
  - OP-IMM → i=1, alu_op={ir[14:12]==3'b101 ? ir[30] : 0, ir[14:12]}.
  - LOAD → i=1, alu_op=0000. STORE → s=1, alu_op=0000.
  - BRANCH → branch=1; alu_op=1000 for beq/bne/blt/bge, 0011 for bltu/bgeu.
  - JAL → jal=1. JALR → i=1, jalr=1, alu_op=0000.
  - LUI → ui=1, u_control=1. AUIPC → ui=1, u_control=0.
  - Any other opcode → state goes to HALT, halted=1.
- EXEC (1 cycle): registers next_pc. Rules below are in priority order:
  - jalr → aluout & ~1.
  - jal → pcimm.
  - Taken branch → pcimm.
  - Otherwise → pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0).
  - Branch taken conditions:
    - beq: Z. bne: ~Z.
    - blt: N^V. bge: ~(N^V).
    - bltu: ~Z. bgeu: Z.
  - Next state: LOAD/STORE → MEM; all others → WB.
- MEM:
  - dmem_re (load) or dmem_we (store) held until an edge with dmem_ready=1, then state goes to WB.
  - No timeout.
- WB (1 cycle):
  - rf_we=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC when ir[11:7]!=0.
  - rf_we=0 for rd=0, STORE and BRANCH.
  - wb_mem=1 only for LOAD.
  - pc<=next_pc at the end of WB; state goes to FETCH; strobes clear.
- HALT: terminal. All strobes and imem_req stay 0 until reset.
- Latency: minimum 4 cycles for non-memory instructions and 5 for loads/stores, plus wait cycles spent in FETCH and MEM.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093), imem_valid on first request → ir latched, i=1, alu_op=0000; rf_we pulses on cycle 4; pc=4 after WB.
- sub x3,x1,x2 (0x402081B3) with imem_valid delayed 3 cycles → imem_req stays high 4 cycles; alu_op=1000, r=1; rf_we one cycle.
- beq at pc=0x10 with pcimm=0x40, Z=1 → pc=0x40, rf_we=0. Same case with Z=0 → pc=0x14. blt with N=1,V=1 → not taken.
- jalr at pc=0x20 with aluout=0x103 → pc=0x102; jalr=1 during DECODE–WB; rf_we=1.
- lw with dmem_ready delayed 2 cycles → dmem_re high 3 cycles, then WB with wb_mem=1 and rf_we=1. sw → dmem_we, rf_we=0.
- Opcode 0x0000007F → halted=1, no further imem_req. Reset asserted mid-MEM → dmem_re drops immediately, pc=RESET_PC, state FETCH.
